// File: rtl/dcache_wb_direct_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_wb_direct_pkg
// Description : Shared types and geometry for the direct-mapped write-back
//               data cache: FSM state encoding, block/word/address widths
//               and a word-select helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_wb_direct_pkg;

    localparam int WORDS_PER_BLOCK = 4;
    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = WORDS_PER_BLOCK * WORD_W;   // 128
    localparam int OFF_W           = $clog2(WORDS_PER_BLOCK);    // 2
    localparam int WADDR_W         = 30;
    localparam int BADDR_W         = WADDR_W - OFF_W;            // 28

    typedef enum logic [1:0] {
        ST_COMPARE   = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } cache_state_t;

    // Pick one 32-bit word out of a block; word 0 lives in [31:0].
    function automatic logic [WORD_W-1:0] select_word(
        input logic [BLOCK_W-1:0] blk,
        input logic [OFF_W-1:0]   off
    );
        return blk[off*WORD_W +: WORD_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_wb_direct_line_store.sv
`default_nettype none
// ============================================================================
// Module      : dcache_line_store
// Description : Valid/dirty/tag/data storage for the direct-mapped cache.
//               One combinational read port by index, one word-write port
//               (marks the line dirty), one full-line fill port (valid,
//               clean, new tag) and a dirty-clear port used after writeback.
// Ports       : clk, rst_n              - clock, async active-low reset
//               rd_idx -> rd_valid/rd_dirty/rd_tag/rd_data
//               wr_en, wr_idx, wr_off, wr_word       - word store
//               fill_en, fill_idx, fill_tag, fill_data - line refill
//               clean_en, clean_idx                  - clear dirty bit
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_line_store
    import dcache_wb_direct_pkg::*;
#(
    parameter int NUM_BLOCKS = 8,
    parameter int IDX_W      = $clog2(NUM_BLOCKS),
    parameter int TAG_W      = BADDR_W - IDX_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_valid,
    output logic                 rd_dirty,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [BLOCK_W-1:0]   rd_data,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [OFF_W-1:0]     wr_off,
    input  logic [WORD_W-1:0]    wr_word,
    input  logic                 fill_en,
    input  logic [IDX_W-1:0]     fill_idx,
    input  logic [TAG_W-1:0]     fill_tag,
    input  logic [BLOCK_W-1:0]   fill_data,
    input  logic                 clean_en,
    input  logic [IDX_W-1:0]     clean_idx
);

    logic [NUM_BLOCKS-1:0] r_valid;
    logic [NUM_BLOCKS-1:0] r_dirty;
    logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    r_data [NUM_BLOCKS];

    assign rd_valid = r_valid[rd_idx];
    assign rd_dirty = r_dirty[rd_idx];
    assign rd_tag   = r_tag[rd_idx];
    assign rd_data  = r_data[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (clean_en) begin
                r_dirty[clean_idx] <= 1'b0;
            end
            // Fill wins over a word store; the controller never issues both.
            if (fill_en) begin
                r_valid[fill_idx] <= 1'b1;
                r_dirty[fill_idx] <= 1'b0;
                r_tag[fill_idx]   <= fill_tag;
                r_data[fill_idx]  <= fill_data;
            end else if (wr_en) begin
                r_dirty[wr_idx] <= 1'b1;
                r_data[wr_idx][wr_off*WORD_W +: WORD_W] <= wr_word;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_wb_direct.sv
`default_nettype none
// ============================================================================
// Module      : dcache_wb_direct
// Description : Direct-mapped, write-back, write-allocate data cache between
//               the pipeline MEM-stage data port and a 128-bit block memory.
//               Hits complete with no stall; misses write back a dirty
//               victim (if any), fetch the block, then replay as a hit.
// Ports       : clk, rst_n                         - clock, async low reset
//               proc_read/write/addr/wdata         - pipeline request
//               proc_stall, proc_rdata             - pipeline response (comb)
//               mem_read/write/addr/wdata          - registered memory strobes
//               mem_rdata, mem_ready               - memory response
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_wb_direct
    import dcache_wb_direct_pkg::*;
#(
    parameter int NUM_BLOCKS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 proc_read,
    input  logic                 proc_write,
    input  logic [WADDR_W-1:0]   proc_addr,
    input  logic [WORD_W-1:0]    proc_wdata,
    output logic                 proc_stall,
    output logic [WORD_W-1:0]    proc_rdata,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [BADDR_W-1:0]   mem_addr,
    output logic [BLOCK_W-1:0]   mem_wdata,
    input  logic [BLOCK_W-1:0]   mem_rdata,
    input  logic                 mem_ready
);

    localparam int IDX_W = $clog2(NUM_BLOCKS);
    localparam int TAG_W = BADDR_W - IDX_W;

    cache_state_t r_state;

    logic [OFF_W-1:0]   w_off;
    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_req;
    logic               w_hit;
    logic               w_line_valid;
    logic               w_line_dirty;
    logic [TAG_W-1:0]   w_line_tag;
    logic [BLOCK_W-1:0] w_line_data;
    logic               w_word_wr;
    logic               w_fill;
    logic               w_clean;

    assign w_off = proc_addr[OFF_W-1:0];
    assign w_idx = proc_addr[OFF_W +: IDX_W];
    assign w_tag = proc_addr[WADDR_W-1 -: TAG_W];

    assign w_req = proc_read | proc_write;
    assign w_hit = w_req & w_line_valid & (w_line_tag == w_tag);

    assign proc_stall = (r_state != ST_COMPARE) | (w_req & ~w_hit);
    assign proc_rdata = select_word(w_line_data, w_off);

    // Store-hit only in COMPARE, which also covers the replay of a write miss.
    assign w_word_wr = (r_state == ST_COMPARE) & proc_write & w_hit;
    assign w_fill    = (r_state == ST_ALLOCATE) & mem_ready;
    assign w_clean   = (r_state == ST_WRITEBACK) & mem_ready;

    dcache_line_store #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W)
    ) u_line_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (w_idx),
        .rd_valid  (w_line_valid),
        .rd_dirty  (w_line_dirty),
        .rd_tag    (w_line_tag),
        .rd_data   (w_line_data),
        .wr_en     (w_word_wr),
        .wr_idx    (w_idx),
        .wr_off    (w_off),
        .wr_word   (proc_wdata),
        .fill_en   (w_fill),
        .fill_idx  (w_idx),
        .fill_tag  (w_tag),
        .fill_data (mem_rdata),
        .clean_en  (w_clean),
        .clean_idx (w_idx)
    );

    // Controller: the request is held stable during a miss, so the index and
    // tag decoded from proc_addr stay valid through WRITEBACK and ALLOCATE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_COMPARE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (r_state)
                ST_COMPARE: begin
                    if (w_req && !w_hit) begin
                        if (w_line_valid && w_line_dirty) begin
                            r_state   <= ST_WRITEBACK;
                            mem_write <= 1'b1;
                            mem_addr  <= {w_line_tag, w_idx};
                            mem_wdata <= w_line_data;
                        end else begin
                            r_state   <= ST_ALLOCATE;
                            mem_read  <= 1'b1;
                            mem_addr  <= proc_addr[WADDR_W-1:OFF_W];
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ready) begin
                        r_state   <= ST_ALLOCATE;
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                        mem_addr  <= proc_addr[WADDR_W-1:OFF_W];
                    end
                end
                ST_ALLOCATE: begin
                    if (mem_ready) begin
                        r_state  <= ST_COMPARE;
                        mem_read <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_COMPARE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_wb_direct.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_wb_direct
// Description : Directed self-checking bench for dcache_wb_direct: cold
//               miss, hits, store hit, dirty eviction, write-allocate and
//               reset in the middle of a fetch.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_wb_direct;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int n_cmp = 0;
    int n_err = 0;

    int           stalls;
    bit           saw_wr, saw_rd, overlap;
    logic [27:0]  wr_addr, rd_addr;
    logic [127:0] wr_data;

    dcache_wb_direct #(.NUM_BLOCKS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] d);
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = a;
        proc_wdata = d;
    endtask

    // Memory model for one miss: answers a writeback after W cycles and a
    // fetch after N cycles (counted from the strobe rising), counts stall
    // cycles and records what the cache put on the memory bus.
    task automatic service(input int W, input int N, input logic [127:0] fill,
                           output int st, output bit swr, output logic [27:0] wa,
                           output logic [127:0] wd, output bit srd,
                           output logic [27:0] ra, output bit ovl);
        int since;
        since = 0; st = 0; swr = 0; srd = 0; ovl = 0;
        wa = '0; wd = '0; ra = '0;
        while (proc_stall && st < 100) begin
            st++;
            mem_ready = 1'b0;
            if (mem_read && mem_write) ovl = 1;
            if (mem_write && !swr) begin swr = 1; wa = mem_addr; wd = mem_wdata; end
            if (mem_read && !srd) begin srd = 1; ra = mem_addr; end
            if (mem_write || mem_read) begin
                since++;
                if (since == (mem_write ? W : N)) begin
                    mem_ready = 1'b1;
                    mem_rdata = fill;
                    since     = 0;
                end
            end
            tick();
            mem_ready = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        req(0, 0, 30'h0, 32'h0);

        // Reset state
        #12;
        check("rst_mem_read",  mem_read,   1'b0);
        check("rst_mem_write", mem_write,  1'b0);
        check("rst_mem_addr",  mem_addr,   28'h0);
        check("rst_mem_wdata", mem_wdata,  128'h0);
        check("rst_stall",     proc_stall, 1'b0);
        check("rst_rdata",     proc_rdata, 32'h0);
        #3 rst_n = 1'b1;
        tick();

        // Cold read miss, N=3
        req(1, 0, 30'h10, 32'h0);
        #1;
        check("cold_stall_now", proc_stall, 1'b1);
        service(0, 3, 128'h00000004_00000003_00000002_00000001,
                stalls, saw_wr, wr_addr, wr_data, saw_rd, rd_addr, overlap);
        check("cold_stalls",  stalls,  4);
        check("cold_fetch",   saw_rd,  1'b1);
        check("cold_addr",    rd_addr, 28'h4);
        check("cold_no_wb",   saw_wr,  1'b0);
        check("cold_overlap", overlap, 1'b0);
        check("cold_hit_stall", proc_stall, 1'b0);
        check("cold_rdata",   proc_rdata, 32'h1);
        tick();

        // Read hit on the next word
        req(1, 0, 30'h11, 32'h0);
        #1;
        check("hit_stall", proc_stall, 1'b0);
        check("hit_rdata", proc_rdata, 32'h2);
        check("hit_no_rd", mem_read,   1'b0);
        check("hit_no_wr", mem_write,  1'b0);
        tick();

        // Write hit, then read it back
        req(0, 1, 30'h12, 32'hDEADBEEF);
        #1;
        check("wrhit_stall", proc_stall, 1'b0);
        tick();
        req(1, 0, 30'h12, 32'h0);
        #1;
        check("wrhit_rd_stall", proc_stall, 1'b0);
        check("wrhit_rdata",    proc_rdata, 32'hDEADBEEF);
        tick();

        // Conflict read on dirty line: W=2, N=3
        req(1, 0, 30'h30, 32'h0);
        #1;
        service(2, 3, 128'h00000008_00000007_00000006_00000005,
                stalls, saw_wr, wr_addr, wr_data, saw_rd, rd_addr, overlap);
        check("evict_stalls",  stalls,  6);
        check("evict_wb",      saw_wr,  1'b1);
        check("evict_wb_addr", wr_addr, 28'h4);
        check("evict_wb_data", wr_data, 128'h00000004_DEADBEEF_00000002_00000001);
        check("evict_fetch",   saw_rd,  1'b1);
        check("evict_rd_addr", rd_addr, 28'hC);
        check("evict_overlap", overlap, 1'b0);
        check("evict_rdata",   proc_rdata, 32'h5);
        check("evict_stall",   proc_stall, 1'b0);
        tick();

        // Write miss on an invalid line, N=2
        req(0, 1, 30'h24, 32'h12345678);
        #1;
        service(0, 2, 128'h0000000C_0000000B_0000000A_00000009,
                stalls, saw_wr, wr_addr, wr_data, saw_rd, rd_addr, overlap);
        check("wmiss_stalls",  stalls,  3);
        check("wmiss_no_wb",   saw_wr,  1'b0);
        check("wmiss_rd_addr", rd_addr, 28'h9);
        check("wmiss_replay",  proc_stall, 1'b0);
        tick();
        req(1, 0, 30'h24, 32'h0);
        #1;
        check("wmiss_rd_store", proc_rdata, 32'h12345678);
        req(1, 0, 30'h25, 32'h0);
        #1;
        check("wmiss_rd_fill",  proc_rdata, 32'hA);
        tick();

        // The write-allocated line must now be dirty: evict it, W=2, N=1
        req(1, 0, 30'h04, 32'h0);
        #1;
        service(2, 1, 128'h00000013_00000012_00000011_00000010,
                stalls, saw_wr, wr_addr, wr_data, saw_rd, rd_addr, overlap);
        check("dirty2_stalls",  stalls,  4);
        check("dirty2_wb",      saw_wr,  1'b1);
        check("dirty2_wb_addr", wr_addr, 28'h9);
        check("dirty2_wb_data", wr_data, 128'h0000000C_0000000B_0000000A_12345678);
        check("dirty2_rd_addr", rd_addr, 28'h1);
        check("dirty2_rdata",   proc_rdata, 32'h10);
        tick();

        // Reset during ALLOCATE
        req(1, 0, 30'h40, 32'h0);
        #1;
        tick();
        tick();
        check("rstmid_strobe_up", mem_read, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_mem_read",  mem_read,  1'b0);
        check("rstmid_mem_write", mem_write, 1'b0);
        check("rstmid_mem_addr",  mem_addr,  28'h0);
        req(0, 0, 30'h40, 32'h0);
        #1;
        check("rstmid_stall", proc_stall, 1'b0);
        check("rstmid_rdata", proc_rdata, 32'h0);
        #1 rst_n = 1'b1;
        tick();

        // Previously cached block must miss again
        req(1, 0, 30'h30, 32'h0);
        #1;
        check("post_rst_miss", proc_stall, 1'b1);
        service(0, 1, 128'h00000008_00000007_00000006_00000005,
                stalls, saw_wr, wr_addr, wr_data, saw_rd, rd_addr, overlap);
        check("post_rst_stalls",  stalls,  2);
        check("post_rst_no_wb",   saw_wr,  1'b0);
        check("post_rst_rd_addr", rd_addr, 28'hC);
        check("post_rst_rdata",   proc_rdata, 32'h5);
        tick();
        req(0, 0, 30'h0, 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
